// File: rtl/hwsec_pkg.sv
// Shared constants and state encoding for the message padder.
package hwsec_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int LEN_W       = 64;
  localparam logic [WORD_W-1:0] PAD_MARKER = 32'h8000_0000;

  typedef enum logic [2:0] {
    PASS   = 3'd0,
    PAD80  = 3'd1,
    ZEROX  = 3'd2,
    ZERO   = 3'd3,
    LEN_HI = 3'd4,
    LEN_LO = 3'd5
  } pad_state_e;

  // State following the word that carries the 0x80 marker at block index idx.
  // idx 13 leaves room only for the length; idx 14 spills; idx 15 starts a fresh block.
  function automatic pad_state_e pad_next(input logic [3:0] idx);
    if (idx == 4'd13)      return LEN_HI;
    else if (idx == 4'd14) return ZEROX;
    else                   return ZERO;
  endfunction

endpackage

// File: rtl/pad_word_reg.sv
// Valid/ready output register holding one padded word and its block flags.
module pad_word_reg
  import hwsec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_first,
  input  logic              i_last_word,
  input  logic              i_msg_end,
  input  logic              i_ready,
  output logic              o_can_load,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data,
  output logic              o_first,
  output logic              o_last_word,
  output logic              o_msg_end
);

  logic              r_valid;
  logic [WORD_W-1:0] r_data;
  logic              r_first;
  logic              r_last_word;
  logic              r_msg_end;

  assign o_can_load  = !r_valid || i_ready;
  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_first     = r_first;
  assign o_last_word = r_last_word;
  assign o_msg_end   = r_msg_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_first     <= 1'b0;
      r_last_word <= 1'b0;
      r_msg_end   <= 1'b0;
    end else if (i_load) begin
      r_valid     <= 1'b1;
      r_data      <= i_data;
      r_first     <= i_first;
      r_last_word <= i_last_word;
      r_msg_end   <= i_msg_end;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/msg_pad_feeder.sv
// Word-serial SHA-2 style padder: passes message words, then emits 0x80 marker,
// zero fill and the 64-bit bit-length so every message ends on a 16-word boundary.
module msg_pad_feeder
  import hwsec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [1:0]        in_bytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last_word,
  output logic              out_msg_end
);

  pad_state_e        r_state;
  // Index of the next word to be loaded into the output register.
  logic [3:0]        r_word_idx;
  logic [LEN_W-1:0]  r_bit_len;

  logic              w_can_load;
  logic              w_avail;
  logic              w_load;
  logic [WORD_W-1:0] w_word;

  always_comb begin
    w_avail = 1'b1;
    w_word  = '0;
    case (r_state)
      PASS: begin
        w_avail = in_valid;
        w_word  = in_data;
        if (in_last) begin
          case (in_bytes)
            2'd1:    w_word = {in_data[31:24], 8'h80, 16'h0000};
            2'd2:    w_word = {in_data[31:16], 8'h80, 8'h00};
            2'd3:    w_word = {in_data[31:8], 8'h80};
            default: w_word = in_data;
          endcase
        end
      end
      PAD80:   w_word = PAD_MARKER;
      LEN_HI:  w_word = r_bit_len[63:32];
      LEN_LO:  w_word = r_bit_len[31:0];
      default: w_word = '0;
    endcase
  end

  assign in_ready = (r_state == PASS) && w_can_load;
  assign w_load   = w_can_load && w_avail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PASS;
      r_word_idx <= '0;
      r_bit_len  <= '0;
    end else if (w_load) begin
      r_word_idx <= r_word_idx + 4'd1;
      case (r_state)
        PASS: begin
          if (in_last && (in_bytes != 2'd0)) begin
            r_bit_len <= r_bit_len + LEN_W'({in_bytes, 3'b000});
            r_state   <= pad_next(r_word_idx);
          end else begin
            r_bit_len <= r_bit_len + LEN_W'(WORD_W);
            if (in_last) r_state <= PAD80;
          end
        end
        PAD80:   r_state <= pad_next(r_word_idx);
        ZEROX:   if (r_word_idx == 4'd15) r_state <= ZERO;
        ZERO:    if (r_word_idx == 4'd13) r_state <= LEN_HI;
        LEN_HI:  r_state <= LEN_LO;
        LEN_LO: begin
          r_state   <= PASS;
          r_bit_len <= '0;
        end
        default: r_state <= PASS;
      endcase
    end
  end

  pad_word_reg u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_data      (w_word),
    .i_first     (r_word_idx == 4'd0),
    .i_last_word (r_word_idx == 4'd15),
    .i_msg_end   (r_state == LEN_LO),
    .i_ready     (out_ready),
    .o_can_load  (w_can_load),
    .o_valid     (out_valid),
    .o_data      (out_data),
    .o_first     (out_first),
    .o_last_word (out_last_word),
    .o_msg_end   (out_msg_end)
  );

endmodule
